// File: rtl/aurora_pkg.sv
// aurora_pkg: shared types for the Aurora TX arbiter.
// Holds the arbiter FSM state encoding and the cfg_mode codes.
// No ports; imported by aurora_arb_pick and aurora_tx_arb.
package aurora_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_GAP   = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  localparam logic [1:0] MODE_S0   = 2'd0;  // s0 only
  localparam logic [1:0] MODE_S1   = 2'd1;  // s1 only (loopback)
  localparam logic [1:0] MODE_RR   = 2'd2;  // round-robin
  localparam logic [1:0] MODE_PRIO = 2'd3;  // s0 priority

endpackage

// File: rtl/aurora_arb_pick.sv
// aurora_arb_pick: combinational source selection for the Aurora TX arbiter.
// Ports: req_i = {s1 valid, s0 valid}, mode_i = cfg_mode code, last_i = last
//        granted source; grant_o = chosen source index, valid_o = a source is eligible.
module aurora_arb_pick
  import aurora_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic [1:0] mode_i,
  input  logic       last_i,
  output logic       grant_o,
  output logic       valid_o
);

  always_comb begin
    grant_o = 1'b0;
    valid_o = 1'b0;
    case (mode_i)
      MODE_S0: begin
        valid_o = req_i[0];
      end
      MODE_S1: begin
        valid_o = req_i[1];
        grant_o = 1'b1;
      end
      MODE_RR: begin
        valid_o = |req_i;
        // On a tie, hand the bus to whichever source did not own it last.
        if (&req_i) grant_o = ~last_i;
        else        grant_o = req_i[1];
      end
      default: begin
        valid_o = |req_i;
        grant_o = ~req_i[0];
      end
    endcase
  end

endmodule

// File: rtl/aurora_tx_arb.sv
// aurora_tx_arb: two-source AXI-Stream packet arbiter feeding the Aurora TX.
// Ports: user_clk/sys_reset (async active-high), channel_up, cfg_mode/cfg_gap,
//        s0/s1 AXI-Stream slaves, m AXI-Stream master, grant/busy, stat_* counters.
// Optional macro AURORA_TX_ARB_STATS_EN enables the stat_* counters (else tied to 0).
module aurora_tx_arb
  import aurora_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int GAP_W  = 16
) (
  input  logic              user_clk,
  input  logic              sys_reset,
  input  logic              channel_up,
  input  logic [1:0]        cfg_mode,
  input  logic [GAP_W-1:0]  cfg_gap,
  input  logic              s0_axis_tvalid,
  input  logic [DATA_W-1:0] s0_axis_tdata,
  input  logic              s0_axis_tlast,
  output logic              s0_axis_tready,
  input  logic              s1_axis_tvalid,
  input  logic [DATA_W-1:0] s1_axis_tdata,
  input  logic              s1_axis_tlast,
  output logic              s1_axis_tready,
  output logic              m_axis_tvalid,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              grant,
  output logic              busy,
  output logic [31:0]       stat_pkt0,
  output logic [31:0]       stat_pkt1,
  output logic [31:0]       stat_flush
);

  state_e             state_q, state_d;
  logic               grant_q, grant_d;
  logic               last_q, last_d;     // round-robin history, resets to 1 so s0 wins first tie
  logic [GAP_W-1:0]   gap_q, gap_d;       // sampled gap, then counted down in GAP

  logic               pick_gnt, pick_vld;
  logic               sel_vld, sel_last, sel_rdy;
  logic [DATA_W-1:0]  sel_data;
  logic               pkt_done, flush_done;

  aurora_arb_pick u_pick (
    .req_i   ({s1_axis_tvalid, s0_axis_tvalid}),
    .mode_i  (cfg_mode),
    .last_i  (last_q),
    .grant_o (pick_gnt),
    .valid_o (pick_vld)
  );

  assign sel_vld  = grant_q ? s1_axis_tvalid : s0_axis_tvalid;
  assign sel_last = grant_q ? s1_axis_tlast  : s0_axis_tlast;
  assign sel_data = grant_q ? s1_axis_tdata  : s0_axis_tdata;

  // A tlast handshake in PASS completes the packet even if channel_up drops that cycle.
  assign pkt_done   = (state_q == ST_PASS)  && sel_vld && m_axis_tready && sel_last;
  assign flush_done = (state_q == ST_FLUSH) && sel_vld && sel_last;

  assign grant = grant_q;
  assign busy  = (state_q != ST_IDLE);

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    gap_d         = gap_q;
    sel_rdy       = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (channel_up && pick_vld) begin
          state_d = ST_PASS;
          grant_d = pick_gnt;
          last_d  = pick_gnt;
          gap_d   = cfg_gap;
        end
      end
      ST_PASS: begin
        m_axis_tvalid = sel_vld;
        m_axis_tdata  = sel_data;
        m_axis_tlast  = sel_last;
        sel_rdy       = m_axis_tready;
        if (pkt_done) begin
          state_d = (gap_q != '0) ? ST_GAP : ST_IDLE;
        end else if (!channel_up) begin
          state_d = ST_FLUSH;
        end
      end
      ST_GAP: begin
        // gap_q is nonzero on entry; the last GAP cycle is the one that sees 1.
        gap_d = gap_q - GAP_W'(1);
        if (gap_q == GAP_W'(1)) state_d = ST_IDLE;
      end
      ST_FLUSH: begin
        sel_rdy = 1'b1;
        if (flush_done) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    s0_axis_tready = sel_rdy && !grant_q;
    s1_axis_tready = sel_rdy &&  grant_q;
  end

  always_ff @(posedge user_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
    end
  end

`ifdef AURORA_TX_ARB_STATS_EN
  logic [31:0] pkt0_q, pkt1_q, flush_q;

  // Free-running counters; natural 32-bit wrap.
  always_ff @(posedge user_clk or posedge sys_reset) begin
    if (sys_reset) begin
      pkt0_q  <= '0;
      pkt1_q  <= '0;
      flush_q <= '0;
    end else begin
      if (pkt_done && !grant_q) pkt0_q  <= pkt0_q + 32'd1;
      if (pkt_done &&  grant_q) pkt1_q  <= pkt1_q + 32'd1;
      if (flush_done)           flush_q <= flush_q + 32'd1;
    end
  end

  assign stat_pkt0  = pkt0_q;
  assign stat_pkt1  = pkt1_q;
  assign stat_flush = flush_q;
`else
  assign stat_pkt0  = '0;
  assign stat_pkt1  = '0;
  assign stat_flush = '0;
`endif

endmodule

// File: tb/tb_aurora_tx_arb.sv
// tb_aurora_tx_arb: self-checking bench for aurora_tx_arb.
// Drives both sources from packet queues, predicts every output each cycle with a
// packet-level model, and checks timing, arbitration order, flush and reset behaviour.
module tb_aurora_tx_arb;

  localparam int DW = 32;
  localparam int GW = 16;
`ifdef AURORA_TX_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          user_clk = 1'b0;
  logic          sys_reset, channel_up;
  logic [1:0]    cfg_mode;
  logic [GW-1:0] cfg_gap;
  logic          s0_axis_tvalid, s0_axis_tlast, s0_axis_tready;
  logic [DW-1:0] s0_axis_tdata;
  logic          s1_axis_tvalid, s1_axis_tlast, s1_axis_tready;
  logic [DW-1:0] s1_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          grant, busy;
  logic [31:0]   stat_pkt0, stat_pkt1, stat_flush;

  always #5 user_clk = ~user_clk;

  aurora_tx_arb #(.DATA_W(DW), .GAP_W(GW)) dut (
    .user_clk(user_clk), .sys_reset(sys_reset), .channel_up(channel_up),
    .cfg_mode(cfg_mode), .cfg_gap(cfg_gap),
    .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tdata(s0_axis_tdata),
    .s0_axis_tlast(s0_axis_tlast), .s0_axis_tready(s0_axis_tready),
    .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tdata(s1_axis_tdata),
    .s1_axis_tlast(s1_axis_tlast), .s1_axis_tready(s1_axis_tready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .grant(grant), .busy(busy),
    .stat_pkt0(stat_pkt0), .stat_pkt1(stat_pkt1), .stat_flush(stat_flush)
  );

  typedef struct packed { logic last; logic [DW-1:0] d; } beat_t;
  beat_t q0[$];
  beat_t q1[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // stimulus knobs
  bit always_vld, rand_rdy, rand_cfg, rand_ch, drop_arm;
  bit hold0, hold1;

  // reference model: owner (-1 = nobody), pending gap cycles, flushing flag
  int m_owner, m_gap_left, m_sgap, m_rr, m_grant;
  bit m_flush;
  int cnt0, cnt1, cntf, exp_beats;

  // observations of the DUT output stream
  int dut_beats;
  int beat_cyc[$];
  int first_gnt[$];
  bit prev_last;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sx(input int v);
    return STATS ? 32'(v) : 32'd0;
  endfunction

  // Eligibility rules, written directly from the mode definitions.
  function automatic int pick(input int mode, input bit v0, input bit v1, input int last);
    if (mode == 0) return v0 ? 0 : -1;
    if (mode == 1) return v1 ? 1 : -1;
    if (mode == 2) begin
      if (v0 && v1) return (last == 0) ? 1 : 0;
      if (v0) return 0;
      if (v1) return 1;
      return -1;
    end
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic push_pkt(input int src, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d    = $urandom;
      b.last = (i == len - 1);
      if (src == 0) q0.push_back(b);
      else          q1.push_back(b);
    end
  endtask

  task automatic clear_obs();
    dut_beats = 0;
    beat_cyc.delete();
    first_gnt.delete();
    prev_last = 1'b1;
  endtask

  task automatic model_reset();
    m_owner = -1; m_gap_left = 0; m_sgap = 0; m_flush = 1'b0;
    m_rr = 1; m_grant = 0;
    cnt0 = 0; cnt1 = 0; cntf = 0; exp_beats = 0;
    hold0 = 1'b0; hold1 = 1'b0;
    q0.delete(); q1.delete();
  endtask

  // Called just after a falling edge; asserts reset with inputs left as they are.
  task automatic do_reset();
    sys_reset = 1'b1;
    #1;
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_s0_tready", s0_axis_tready, 0);
    check("rst_s1_tready", s1_axis_tready, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_stat_pkt0", stat_pkt0, 0);
    check("rst_stat_pkt1", stat_pkt1, 0);
    check("rst_stat_flush", stat_flush, 0);
    s0_axis_tvalid = 0; s1_axis_tvalid = 0;
    s0_axis_tdata = '0; s1_axis_tdata = '0;
    s0_axis_tlast = 0; s1_axis_tlast = 0;
    model_reset();
    clear_obs();
    @(negedge user_clk);
    @(negedge user_clk);
    sys_reset = 1'b0;
  endtask

  task automatic tick();
    bit v0, v1, mr, vw, lw, ev, el, et0, et1, ebusy;
    logic [DW-1:0] dw, ed;
    int w, egrant;
    if (rand_cfg) begin
      cfg_mode = 2'($urandom_range(0, 3));
      cfg_gap  = GW'($urandom_range(0, 3));
    end
    if (rand_ch) channel_up = ($urandom_range(0, 29) != 0);
    if (drop_arm && dut_beats == 1) begin
      channel_up = 1'b0;
      drop_arm   = 1'b0;
    end
    v0 = (q0.size() > 0) && (hold0 || always_vld || $urandom_range(0, 3) != 0);
    v1 = (q1.size() > 0) && (hold1 || always_vld || $urandom_range(0, 3) != 0);
    s0_axis_tvalid = v0;
    s0_axis_tdata  = v0 ? q0[0].d : '0;
    s0_axis_tlast  = v0 ? q0[0].last : 1'b0;
    s1_axis_tvalid = v1;
    s1_axis_tdata  = v1 ? q1[0].d : '0;
    s1_axis_tlast  = v1 ? q1[0].last : 1'b0;
    mr = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    m_axis_tready = mr;
    #2;

    ev = 0; ed = '0; el = 0; et0 = 0; et1 = 0; ebusy = 1; egrant = m_grant;
    if (m_owner < 0 && m_gap_left == 0) begin
      ebusy = 0;
      w = pick(int'(cfg_mode), v0, v1, m_rr);
      if (channel_up && w >= 0) begin
        m_owner = w; m_rr = w; m_grant = w; m_sgap = int'(cfg_gap);
      end
    end else if (m_gap_left > 0) begin
      m_gap_left--;
    end else begin
      w  = m_owner;
      vw = (w == 1) ? v1 : v0;
      dw = (w == 1) ? s1_axis_tdata : s0_axis_tdata;
      lw = (w == 1) ? s1_axis_tlast : s0_axis_tlast;
      if (m_flush) begin
        if (w == 1) et1 = 1; else et0 = 1;
        if (vw && lw) begin
          m_flush = 0; m_owner = -1; cntf++;
        end
      end else begin
        ev = vw; ed = dw; el = lw;
        if (w == 1) et1 = mr; else et0 = mr;
        if (vw && mr) exp_beats++;
        if (vw && mr && lw) begin
          if (w == 1) cnt1++; else cnt0++;
          m_owner = -1; m_gap_left = m_sgap;
        end else if (!channel_up) begin
          m_flush = 1;
        end
      end
    end

    check("m_tvalid", m_axis_tvalid, ev);
    if (ev) begin
      check("m_tdata", m_axis_tdata, ed);
      check("m_tlast", m_axis_tlast, el);
    end
    check("s0_tready", s0_axis_tready, et0);
    check("s1_tready", s1_axis_tready, et1);
    check("grant", grant, egrant);
    check("busy", busy, ebusy);

    if (m_axis_tvalid === 1'b1 && mr) begin
      if (prev_last) first_gnt.push_back(int'(grant));
      beat_cyc.push_back(cyc);
      prev_last = m_axis_tlast;
      dut_beats++;
    end

    if (v0 && et0) begin void'(q0.pop_front()); hold0 = 0; end else hold0 = v0;
    if (v1 && et1) begin void'(q1.pop_front()); hold1 = 0; end else hold1 = v1;

    @(posedge user_clk);
    @(negedge user_clk);
    cyc++;
  endtask

  task automatic run_until_drained(input int maxc);
    int c = 0;
    while ((q0.size() != 0 || q1.size() != 0 || m_owner >= 0 || m_gap_left != 0) && c < maxc) begin
      tick();
      c++;
    end
    check("drain_timeout", (c < maxc), 1);
    repeat (2) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_reset = 0; channel_up = 1; cfg_mode = 2'd0; cfg_gap = '0;
    s0_axis_tvalid = 0; s0_axis_tdata = '0; s0_axis_tlast = 0;
    s1_axis_tvalid = 0; s1_axis_tdata = '0; s1_axis_tlast = 0;
    m_axis_tready = 1;
    always_vld = 1; rand_rdy = 0; rand_cfg = 0; rand_ch = 0; drop_arm = 0;
    model_reset();
    clear_obs();
    @(negedge user_clk);
    do_reset();

    // Mode 0, no gap: three 4-beat packets, one idle cycle between them.
    cfg_mode = 2'd0; cfg_gap = '0;
    for (int i = 0; i < 3; i++) push_pkt(0, 4);
    run_until_drained(200);
    check("t1_beats", dut_beats, 12);
    check("t1_pkt_len_cycles", beat_cyc[3] - beat_cyc[0], 3);
    check("t1_gap01", beat_cyc[4] - beat_cyc[3], 2);
    check("t1_gap12", beat_cyc[8] - beat_cyc[7], 2);
    check("t1_stat_pkt0", stat_pkt0, STATS ? 3 : 0);

    // Round-robin with both sources always valid.
    do_reset();
    cfg_mode = 2'd2;
    for (int i = 0; i < 2; i++) begin
      push_pkt(0, 2);
      push_pkt(1, 2);
    end
    run_until_drained(200);
    check("t2_pkts", first_gnt.size(), 4);
    check("t2_g0", first_gnt[0], 0);
    check("t2_g1", first_gnt[1], 1);
    check("t2_g2", first_gnt[2], 0);
    check("t2_g3", first_gnt[3], 1);
    check("t2_stat_pkt1", stat_pkt1, STATS ? 2 : 0);

    // Gap of 5: last beat to next first beat is 5 GAP + 1 IDLE + 1.
    do_reset();
    cfg_mode = 2'd0; cfg_gap = GW'(5);
    push_pkt(0, 3);
    push_pkt(0, 3);
    run_until_drained(200);
    check("t3_beats", dut_beats, 6);
    check("t3_gap5", beat_cyc[3] - beat_cyc[2], 7);

    // Channel drops on beat 2 of an 8-beat packet: rest is flushed.
    do_reset();
    cfg_mode = 2'd0; cfg_gap = '0;
    push_pkt(0, 8);
    drop_arm = 1;
    run_until_drained(200);
    check("t4_beats_out", dut_beats, 2);
    check("t4_stat_flush", stat_flush, STATS ? 1 : 0);
    check("t4_stat_pkt0", stat_pkt0, 0);
    check("t4_idle", busy, 0);
    channel_up = 1;

    // Randomised traffic: backpressure, bursty valids, cfg changing every cycle.
    do_reset();
    always_vld = 0; rand_rdy = 1; rand_cfg = 1; rand_ch = 1;
    for (int i = 0; i < 40; i++) push_pkt(int'($urandom_range(0, 1)), int'($urandom_range(1, 6)));
    run_until_drained(5000);
    rand_cfg = 0; rand_ch = 0; channel_up = 1;
    check("t5_beats", dut_beats, exp_beats);
    check("t5_stat_pkt0", stat_pkt0, sx(cnt0));
    check("t5_stat_pkt1", stat_pkt1, sx(cnt1));
    check("t5_stat_flush", stat_flush, sx(cntf));

    // Reset in the middle of an s1 packet, then normal traffic afterwards.
    do_reset();
    always_vld = 1; rand_rdy = 0;
    cfg_mode = 2'd1; cfg_gap = '0;
    push_pkt(1, 6);
    repeat (3) tick();
    check("t6_busy_before_rst", busy, 1);
    check("t6_grant_before_rst", grant, 1);
    do_reset();
    cfg_mode = 2'd0;
    push_pkt(0, 2);
    run_until_drained(200);
    check("t6_beats", dut_beats, 2);
    check("t6_stat_pkt0", stat_pkt0, STATS ? 1 : 0);
    check("t6_stat_pkt1", stat_pkt1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
